// File: rtl/mips_pkg.sv
//==============================================================================
// mips_pkg : shared types and widths for the MIPS pipeline control logic
// Rev 1.0
//==============================================================================
`default_nettype none

package mips_pkg;

    localparam int REG_W        = 5;
    localparam int STALL_CNT_W  = 16;
    localparam int STATE_W      = 2;
    localparam int MULDIV_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        S_INIT   = 2'd0,
        S_RUN    = 2'd1,
        S_FREEZE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
//==============================================================================
// load_use_detect : flags an ID instruction that reads the destination of a
//                   load still sitting in EX. Purely combinational.
// Rev 1.0
//==============================================================================
`default_nettype none

module load_use_detect
    import mips_pkg::*;
(
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    output logic             hit
);

    logic w_rs_match;
    logic w_rt_match;

    // $zero never carries a real dependency, so a load into r0 never stalls.
    assign w_rs_match = id_uses_rs && (id_rs == ex_rt);
    assign w_rt_match = id_uses_rt && (id_rt == ex_rt);
    assign hit        = ex_mem_read && (ex_rt != '0) && (w_rs_match || w_rt_match);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
//==============================================================================
// hazard_ctrl : PC / IF-ID / back-end enable sequencing for the 5-stage core.
//               HAZARD_MULDIV_STALL_EN adds the HI/LO read interlock.
// Rev 1.0
//==============================================================================
`default_nettype none

module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_W-1:0]       id_rs,
    input  logic [REG_W-1:0]       id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   ex_mem_read,
    input  logic [REG_W-1:0]       ex_rt,
    input  logic                   branch_taken_ex,
    input  logic                   jump_id,
    input  logic                   imem_ready,
    input  logic                   dmem_req,
    input  logic                   dmem_ready,
    input  logic                   muldiv_start,
    input  logic                   hilo_read_id,
    output logic                   pc_we,
    output logic                   if_id_we,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   back_we,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [MULDIV_CNT_W-1:0] C_MULDIV_LOAD = MULDIV_CNT_W'(MULDIV_CYCLES);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic                   w_frozen;
    logic                   w_load_use;
    logic                   w_hilo_hazard;
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    load_use_detect u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .hit         (w_load_use)
    );

    // S_INIT is treated as a freeze so nothing moves in the first cycle.
    assign w_frozen = (r_state == S_INIT) || (r_state == S_FREEZE) ||
                      ((r_state == S_RUN) && dmem_req && !dmem_ready);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:   w_state_nxt = S_RUN;
            S_RUN:    if (dmem_req && !dmem_ready) w_state_nxt = S_FREEZE;
            S_FREEZE: if (dmem_ready) w_state_nxt = S_RUN;
            default:  w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef HAZARD_MULDIV_STALL_EN
    logic [MULDIV_CNT_W-1:0] r_muldiv_cnt;

    // A new MULT/DIV restarts the count even if one is already in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_muldiv_cnt <= '0;
        end else if (!w_frozen) begin
            if (muldiv_start) begin
                r_muldiv_cnt <= C_MULDIV_LOAD;
            end else if (r_muldiv_cnt != '0) begin
                r_muldiv_cnt <= r_muldiv_cnt - MULDIV_CNT_W'(1);
            end
        end
    end

    assign w_hilo_hazard = hilo_read_id && (r_muldiv_cnt != '0);
`else
    logic w_unused_muldiv;

    assign w_hilo_hazard   = 1'b0;
    assign w_unused_muldiv = ^{muldiv_start, hilo_read_id, C_MULDIV_LOAD};
`endif

    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        back_we      = 1'b1;
        if (w_frozen) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            back_we  = 1'b0;
        end else if (branch_taken_ex) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (jump_id) begin
            if_id_flush = 1'b1;
        end else if (w_hilo_hazard || w_load_use) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (!imem_ready) begin
            pc_we       = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
        end else if (!pc_we && (r_stall_cycles != {STALL_CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire
